// File: rtl/ex_muldiv_if.sv
// Request/result bundle between the EX-stage issue logic and the iterative multiply/divide unit.
// The master drives the op request; the slave returns busy and the writeback result.
interface ex_muldiv_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            busy;
  logic [XLEN-1:0] wdata;
  logic            write;
  logic [4:0]      rdreg;

  modport master (
    output start, flush, funct3, rs1_val, rs2_val, rd_in,
    input  busy, wdata, write, rdreg
  );

  modport slave (
    input  start, flush, funct3, rs1_val, rs2_val, rd_in,
    output busy, wdata, write, rdreg
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign correction in a final fix-up cycle.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);
  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [2*XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0]   op_b_q, op_b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [4:0]        rdreg_q, rdreg_d;

  // Request decode
  logic            is_div_in, signed_a_in, signed_b_in, a_neg_in, b_neg_in;
  logic [XLEN-1:0] a_abs, b_abs, spec_res;
  logic            div_zero, div_ovf, launch;

  always_comb begin
    is_div_in   = bus.funct3[2];
    signed_a_in = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                  (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    signed_b_in = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    a_neg_in    = signed_a_in && bus.rs1_val[XLEN-1];
    b_neg_in    = signed_b_in && bus.rs2_val[XLEN-1];
    a_abs       = a_neg_in ? -bus.rs1_val : bus.rs1_val;
    b_abs       = b_neg_in ? -bus.rs2_val : bus.rs2_val;
    div_zero    = is_div_in && (bus.rs2_val == '0);
    div_ovf     = is_div_in && !bus.funct3[0] && (bus.rs2_val == '1) &&
                  (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}});
    spec_res    = '0;
    if (div_zero) begin
      spec_res = bus.funct3[1] ? bus.rs1_val : '1;
    end else if (div_ovf) begin
      spec_res = bus.funct3[1] ? '0 : bus.rs1_val;
    end
    launch = bus.start && ((state_q == StIdle) || ((state_q == StDone) && !bus.flush));
  end

  // Datapath step and fix-up
  logic [2*XLEN-1:0] mul_sum, prod;
  logic [XLEN:0]     rem_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub, quot_s, rem_s, result;

  always_comb begin
    mul_sum   = acc_q + (op_b_q[0] ? op_a_q : '0);
    rem_shift = acc_q[2*XLEN-1:XLEN-1];
    div_ge    = rem_shift >= {1'b0, op_b_q};
    // True difference is below the divisor, so modular XLEN-bit subtraction is exact
    div_sub   = rem_shift[XLEN-1:0] - op_b_q;
    prod      = qneg_q ? -acc_q : acc_q;
    quot_s    = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s     = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (special_q) begin
      result = acc_q[XLEN-1:0];
    end else begin
      unique case (funct3_q)
        3'b000:                 result = prod[XLEN-1:0];
        3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
        3'b100, 3'b101:         result = quot_s;
        default:                result = rem_s;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    acc_d     = acc_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    special_d = special_q;
    wdata_d   = wdata_q;
    rdreg_d   = rdreg_q;
    write_d   = 1'b0;

    unique case (state_q)
      StIdle: ;
      StCalc: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          if (funct3_q[2]) begin
            acc_d = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};
          end else begin
            acc_d  = mul_sum;
            op_a_d = {op_a_q[2*XLEN-2:0], 1'b0};
            op_b_d = {1'b0, op_b_q[XLEN-1:1]};
          end
          count_d = count_q + 1'b1;
          if (count_q == CntW'(XLEN - 1)) state_d = StFix;
        end
      end
      StFix: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          wdata_d = result;
          rdreg_d = rd_q;
          write_d = (rd_q != 5'd0);
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      funct3_d  = bus.funct3;
      rd_d      = bus.rd_in;
      qneg_d    = a_neg_in ^ b_neg_in;
      rneg_d    = a_neg_in;
      count_d   = '0;
      op_b_d    = b_abs;
      op_a_d    = is_div_in ? '0 : {{XLEN{1'b0}}, a_abs};
      acc_d     = is_div_in ? {{XLEN{1'b0}}, a_abs} : '0;
      special_d = div_zero || div_ovf;
      if (div_zero || div_ovf) begin
        acc_d   = {{XLEN{1'b0}}, spec_res};
        state_d = StFix;
      end else begin
        state_d = StCalc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      acc_q     <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      special_q <= 1'b0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      rdreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      acc_q     <= acc_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      special_q <= special_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      rdreg_q   <= rdreg_d;
    end
  end

  assign bus.busy  = (state_q == StCalc) || (state_q == StFix);
  assign bus.wdata = wdata_q;
  assign bus.write = write_q;
  assign bus.rdreg = rdreg_q;

endmodule
